neuron_multilane: RTL and testbench

Second-generation fixed-point neuron that computes act(sum(x_i*w_i) + bias) over NUM_INPUTS inputs. Inputs are streamed as NUM_LANES values per beat, and each beat is multiplied in parallel lanes. The accumulator is wide, so intermediate sums never overflow, and a single saturate-or-wrap step is applied at the end. The activation function is selectable at run time, and the output uses a valid/ready handshake with backpressure. It replaces the single-lane neuron inside layer arrays.

---
 rtl/neuron_multilane.sv | 135 +++++++++++++
 tb/tb_neuron_multilane.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/neuron_multilane.sv
// neuron_multilane: multi-lane fixed-point neuron, act(sum(x_i*w_i) + bias), with a valid/ready output
module neuron_multilane #(
  parameter int NUM_INPUTS = 4,
  parameter int NUM_LANES  = 2,
  parameter int WIDTH      = 8,
  parameter int FRAC_BITS  = 5,
  parameter int SATURATE   = 1
) (
  input  logic                          CLK,
  input  logic                          RSTN,
  input  logic [NUM_INPUTS*WIDTH-1:0]   WEIGHTS,
  input  logic signed [WIDTH-1:0]       BIAS,
  input  logic [1:0]                    ACT_MODE,
  input  logic [NUM_LANES*WIDTH-1:0]    VALUE_IN,
  input  logic                          VALID_IN,
  output logic                          READY,
  output logic signed [WIDTH-1:0]       VALUE_OUT,
  output logic                          VALID_OUT,
  input  logic                          OUT_READY,
  output logic                          OVERFLOW,
  output logic                          BUSY
);
  localparam int NB    = NUM_INPUTS / NUM_LANES;
  localparam int CW    = NB > 1 ? $clog2(NB) : 1;
  localparam int MW    = 2 * WIDTH;
  localparam int PW    = 2 * WIDTH - FRAC_BITS;
  localparam int ACC_W = PW + $clog2(NUM_INPUTS) + 1;
  localparam int SW    = ACC_W + 1;
  localparam logic signed [SW-1:0]    MAXV = SW'((1 << (WIDTH - 1)) - 1);
  localparam logic signed [SW-1:0]    MINV = ~MAXV;
  localparam logic signed [WIDTH-1:0] MAXN = WIDTH'((1 << (WIDTH - 1)) - 1);
  localparam logic signed [WIDTH-1:0] MINN = ~MAXN;
  localparam logic signed [WIDTH-1:0] ONE  = WIDTH'(1 << FRAC_BITS);
  localparam logic signed [WIDTH-1:0] ZERO = '0;

  typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, FINAL, ACT, OUT} state_t;

  state_t                   state;
  logic [CW-1:0]            cnt;
  logic [1:0]               dcnt, mode;
  logic signed [MW-1:0]     prod [NUM_LANES];
  logic signed [PW-1:0]     p [NUM_LANES];
  logic                     pv, take, hi, lo;
  logic signed [ACC_W-1:0]  acc, lsum;
  logic signed [SW-1:0]     s;
  logic signed [WIDTH-1:0]  nar, leak, act;

  assign take = VALID_IN & READY;

  always_comb begin
    for (int l = 0; l < NUM_LANES; l++)
      prod[l] = MW'($signed(VALUE_IN[l*WIDTH +: WIDTH])) *
                MW'($signed(WEIGHTS[(int'(cnt) * NUM_LANES + l) * WIDTH +: WIDTH]));
  end

  always_comb begin
    lsum = '0;
    for (int l = 0; l < NUM_LANES; l++)
      lsum = lsum + ACC_W'(p[l]);
  end

  assign s    = SW'(acc) + SW'(BIAS);
  assign hi   = s > MAXV;
  assign lo   = s < MINV;
  assign leak = nar >>> 3;
  assign act  = (mode == 2'd0) ? nar :
                nar[WIDTH-1] ? ((mode == 2'd3) ? leak : ZERO) :
                (mode == 2'd2 && nar > ONE) ? ONE : nar;

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state     <= IDLE;
      READY     <= 1'b1;
      VALID_OUT <= 1'b0;
      VALUE_OUT <= '0;
      OVERFLOW  <= 1'b0;
      BUSY      <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      dcnt      <= '0;
      pv        <= 1'b0;
      mode      <= '0;
      nar       <= '0;
    end else begin
      pv <= take;
      if (take)
        for (int l = 0; l < NUM_LANES; l++)
          p[l] <= PW'(prod[l] >>> FRAC_BITS);
      if (take && state == IDLE) begin
        acc      <= '0;
        mode     <= ACT_MODE;
        OVERFLOW <= 1'b0;
      end else if (pv)
        acc <= acc + lsum;
      case (state)
        IDLE, ACCUM: if (take) begin
          BUSY <= 1'b1;
          if (cnt == CW'(NB - 1)) begin
            state <= DRAIN;
            cnt   <= '0;
            READY <= 1'b0;
          end else begin
            state <= ACCUM;
            cnt   <= cnt + 1'b1;
          end
        end
        // Flush the product and accumulate stages, padded so the result appears five edges after the last beat
        DRAIN: begin
          dcnt <= dcnt + 1'b1;
          if (dcnt == 2'd2) begin
            dcnt  <= '0;
            state <= FINAL;
          end
        end
        FINAL: begin
          nar      <= (SATURATE != 0 && hi) ? MAXN : (SATURATE != 0 && lo) ? MINN : s[WIDTH-1:0];
          OVERFLOW <= hi | lo;
          state    <= ACT;
        end
        ACT: begin
          VALUE_OUT <= act;
          VALID_OUT <= 1'b1;
          state     <= OUT;
        end
        OUT: if (OUT_READY) begin
          VALID_OUT <= 1'b0;
          READY     <= 1'b1;
          BUSY      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_neuron_multilane.sv
// tb_neuron_multilane: scoreboard bench comparing saturating and wrapping neurons to an integer reference model
module tb_neuron_multilane;
  logic clk = 0;
  logic rstn = 0;
  always #5 clk = ~clk;

  logic [31:0]       weights = '0;
  logic signed [7:0] bias = '0;
  logic [1:0]        act_mode = '0;
  logic [15:0]       value_in = '0;
  logic              valid_in = 0;
  logic              out_ready = 0;
  logic              ready, valid_out, overflow, busy;
  logic              ready_w, valid_w, overflow_w, busy_w;
  logic signed [7:0] value_out, value_w;

  neuron_multilane #(.SATURATE(1)) dut (
    .CLK(clk), .RSTN(rstn), .WEIGHTS(weights), .BIAS(bias), .ACT_MODE(act_mode),
    .VALUE_IN(value_in), .VALID_IN(valid_in), .READY(ready), .VALUE_OUT(value_out),
    .VALID_OUT(valid_out), .OUT_READY(out_ready), .OVERFLOW(overflow), .BUSY(busy));

  neuron_multilane #(.SATURATE(0)) dut_w (
    .CLK(clk), .RSTN(rstn), .WEIGHTS(weights), .BIAS(bias), .ACT_MODE(act_mode),
    .VALUE_IN(value_in), .VALID_IN(valid_in), .READY(ready_w), .VALUE_OUT(value_w),
    .VALID_OUT(valid_w), .OUT_READY(out_ready), .OVERFLOW(overflow_w), .BUSY(busy_w));

  typedef struct {int v; int o;} exp_t;
  exp_t q_s[$], q_w[$];
  exp_t e_s, e_w;
  int checks = 0, passes = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
  endtask

  // Reference: sum of floor(x*w/32) plus bias, then clamp or wrap, then activation
  function automatic void model(input int x[4], input int w[4], input int b, input int mode,
                                input bit sat, output int val, output int ovf);
    int s, n;
    s = b;
    for (int i = 0; i < 4; i++) s += (x[i] * w[i]) >>> 5;
    ovf = (s > 127 || s < -128) ? 1 : 0;
    if (sat) n = s > 127 ? 127 : (s < -128 ? -128 : s);
    else n = (((s + 128) % 256) + 256) % 256 - 128;
    case (mode)
      0: val = n;
      1: val = n < 0 ? 0 : n;
      2: val = n < 0 ? 0 : (n > 32 ? 32 : n);
      default: val = n < 0 ? (n >>> 3) : n;
    endcase
  endfunction

  always @(negedge clk) begin
    if (valid_out && out_ready) begin
      if (q_s.size() == 0) begin
        checks++;
        $display("FAIL sat_unexpected_output: got %0d, expected none", value_out);
      end else begin
        e_s = q_s.pop_front();
        chk("sat_value", value_out, e_s.v);
        chk("sat_overflow", overflow, e_s.o);
      end
    end
    if (valid_w && out_ready) begin
      if (q_w.size() == 0) begin
        checks++;
        $display("FAIL wrap_unexpected_output: got %0d, expected none", value_w);
      end else begin
        e_w = q_w.pop_front();
        chk("wrap_value", value_w, e_w.v);
        chk("wrap_overflow", overflow_w, e_w.o);
      end
    end
  end

  task automatic drive_beat(input logic [15:0] v);
    int t = 0;
    value_in = v;
    valid_in = 1;
    while (!ready && t < 50) begin @(posedge clk); #1; t++; end
    chk("beat_accepted", int'(t < 50), 1);
    @(posedge clk); #1;
    valid_in = 0;
  endtask

  task automatic infer(input int x[4], input int w[4], input int b, input int mode,
                       input int gap, input int hold, input bit early);
    int v, o, vw, ow, n;
    for (int i = 0; i < 4; i++) weights[i*8 +: 8] = w[i][7:0];
    bias = b[7:0];
    act_mode = mode[1:0];
    out_ready = early;
    model(x, w, b, mode, 1'b1, v, o);
    model(x, w, b, mode, 1'b0, vw, ow);
    q_s.push_back('{v, o});
    q_w.push_back('{vw, ow});
    drive_beat({x[1][7:0], x[0][7:0]});
    chk("busy_mid", busy, 1);
    act_mode = ~mode[1:0];
    repeat (gap) begin @(posedge clk); #1; end
    drive_beat({x[3][7:0], x[2][7:0]});
    n = 0;
    while (!valid_out && n < 20) begin @(posedge clk); #1; n++; end
    chk("latency", n, 5);
    if (!early) begin
      repeat (hold) begin
        chk("hold_value", value_out, v);
        chk("hold_overflow", overflow, o);
        chk("hold_ready", ready, 0);
        valid_in = 1;
        value_in = 16'($urandom);
        @(posedge clk); #1;
      end
      valid_in = 0;
      out_ready = 1;
    end
    @(posedge clk); #1;
    out_ready = 0;
    chk("ready_after", ready, 1);
    chk("valid_after", valid_out, 0);
    chk("busy_after", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int x32[4], x96[4], w16[4], wn16[4], w96[4], rx[4], rw[4];
    for (int i = 0; i < 4; i++) begin
      x32[i] = 32; x96[i] = 96; w16[i] = 16; wn16[i] = -16; w96[i] = 96;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", ready, 1);
    chk("reset_valid", valid_out, 0);
    chk("reset_value", value_out, 0);
    chk("reset_overflow", overflow, 0);
    chk("reset_busy", busy, 0);
    rstn = 1;
    @(posedge clk); #1;

    infer(x32, w16, 0, 0, 0, 0, 0);
    infer(x32, wn16, 0, 1, 0, 0, 0);
    infer(x32, wn16, 0, 3, 0, 0, 0);
    infer(x32, w16, 0, 2, 0, 0, 0);
    infer(x32, w16, -96, 2, 0, 0, 0);
    infer(x96, w96, 0, 0, 0, 0, 0);
    infer(x32, w16, 0, 0, 0, 0, 0);
    infer(x96, w96, 0, 0, 0, 6, 0);
    infer(x32, w16, 0, 0, 0, 6, 0);
    infer(x32, w16, 0, 0, 3, 0, 0);

    for (int i = 0; i < 4; i++) weights[i*8 +: 8] = 8'd16;
    drive_beat({8'd32, 8'd32});
    rstn = 0;
    @(posedge clk); #1;
    rstn = 1;
    chk("midreset_ready", ready, 1);
    chk("midreset_valid", valid_out, 0);
    chk("midreset_busy", busy, 0);
    infer(x32, w16, 0, 0, 0, 0, 0);
    infer(x32, w16, 0, 0, 1, 0, 1);

    for (int k = 0; k < 25; k++) begin
      for (int i = 0; i < 4; i++) begin
        rx[i] = int'($urandom_range(0, 255)) - 128;
        rw[i] = int'($urandom_range(0, 255)) - 128;
      end
      infer(rx, rw, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 3)),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("sat_queue_empty", q_s.size(), 0);
    chk("wrap_queue_empty", q_w.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
